mem_address_sequencer: RTL
==========================

// Module: mem_address_sequencer
// PURPOSE
// Parametrised successor to the 8-bit memory address register: holds the RAM address driven to memory,
// loaded from the shared CPU bus, plus single-step inc/dec and a self-timed burst mode that walks N
// consecutive addresses under a valid/ready handshake. Sits between the bus and RAM address port.
// PARAMETERS
// BUS_W      16  width of shared Bus
// ADDR_W      8  address width; must be <= BUS_W
// LEN_W       4  burst length field width; must be <= BUS_W; burst = Len+1 words (1..2^LEN_W)
// WRAP_MODE   1  1: address wraps modulo 2^ADDR_W; 0: address saturates at 0 / all-ones
// PORTS
// Clk         in    1       system clock, all state on rising edge
// Rst         in    1       synchronous reset, ACTIVE-LOW (Rst==0 at posedge resets)
// Bus         inout BUS_W   shared bus; read-only here, block never drives it (held Z)
// RegIn       in    1       load address <= Bus[ADDR_W-1:0]
// LenIn       in    1       load burst length <= Bus[LEN_W-1:0]
// Inc / Dec   in    1       single step address +1 / -1
// Start       in    1       begin burst from current address
// Dir         in    1       burst direction, 0 up / 1 down; sampled on accepted Start
// AddrReady   in    1       memory accepts current address
// ClrFlags    in    1       clears Wrapped
// AddressOut  out   ADDR_W  registered address to memory
// AddrValid   out   1       burst address valid this cycle
// Busy        out   1       state != IDLE
// Done        out   1       one-cycle pulse after last burst handshake
// Wrapped     out   1       sticky: any step crossed/hit the address boundary
// BEHAVIOUR
// - Reset: AddressOut=0, Len=0, AddrValid=0, Busy=0, Done=0, Wrapped=0, state IDLE. Reset mid-burst
//   aborts same edge; no further handshakes; Done not pulsed.
// - All outputs registered (AddrValid/Busy/Done decoded from registered state). Latency 1 clk.
// - FSM: IDLE -> RUN on Start; RUN -> DONE on AddrValid&&AddrReady with Remaining==0; DONE -> IDLE
//   unconditionally after 1 cycle. AddrValid=1 only in RUN; Done=1 only in DONE.
// - IDLE command priority: RegIn, LenIn independent and may coincide; then Inc > Dec (both -> Inc only).
//   Start with RegIn/LenIn same cycle: burst uses newly loaded address/length. Start with Inc/Dec:
//   Start wins, step ignored.
// - RUN/DONE: RegIn, LenIn, Inc, Dec, Start ignored (no queuing). Dir latched at Start.
// - RUN: Remaining loaded with Len at Start. Per handshake: address steps by Dir, Remaining-=1.
//   AddrValid held with stable AddressOut until AddrReady. Final handshake does NOT step the
//   address: AddressOut holds last issued address.
// - Boundary, WRAP_MODE=1: all-ones +1 -> 0, 0 -1 -> all-ones; sets Wrapped.
//   WRAP_MODE=0: all-ones +1 and 0 -1 hold value; sets Wrapped; burst continues re-issuing held address.
// - Wrapped: set on boundary step, cleared by ClrFlags; set wins if both same cycle.
// - Bus bits above ADDR_W / LEN_W ignored. Bus is never driven (assign Bus = {BUS_W{1'bz}} not needed).
// STRUCTURE
// - Shared header mem_addr_defs.vh: FSM state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2), DIR_UP/DIR_DN.
// - One sub-module: address_stepper (combinational): in addr, dir, WRAP_MODE -> next addr, boundary flag.
//   Reused for both single steps and burst steps.
// - Two-process style: combinational next-state, one clocked block with synchronous active-low reset.
// TESTING
// - Reset: Rst=0 mid-burst (Len=7, 3 beats done) -> next edge AddressOut=0, Busy=0, AddrValid=0, no Done.
// - Load+burst: Bus=16'h0040 RegIn, Bus=3 LenIn, Start Dir=0, AddrReady=1 -> addresses 40,41,42,43,
//   Done pulse 1 cycle later, AddressOut stays 43, Busy low after Done.
// - Backpressure: AddrReady toggled 1,0,0,1 -> AddressOut/AddrValid stable while AddrReady=0; beat count exact.
// - Wrap: addr=FE, Len=3, Dir=0, WRAP_MODE=1 -> FE,FF,00,01, Wrapped=1; ClrFlags -> 0.
// - Saturate: WRAP_MODE=0, addr=01, Len=3, Dir=1 -> 01,00,00,00, Wrapped=1.
// - Priority: Inc&Dec in IDLE -> +1; Start&Inc -> burst from unstepped addr; RegIn during RUN ignored.

Source files
------------

// File: rtl/mem_address_sequencer_pkg.sv
// Shared FSM state encoding and burst-direction codes for the address sequencer.
// No logic; types only.
// No flow control.
package mem_address_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/mem_address_sequencer_address_stepper.sv
// One-step address increment/decrement with wrap or saturate at the boundary.
// Purely combinational, zero latency.
// No flow control.
module mem_address_sequencer_address_stepper
    import mem_address_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int WRAP_MODE = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              dir,
    output logic [ADDR_W-1:0] next_addr,
    output logic              boundary
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    always_comb begin
        boundary  = (dir == DIR_DN) ? (addr == '0) : (addr == '1);
        next_addr = (dir == DIR_DN) ? (addr - ONE) : (addr + ONE);
        // Saturating variant parks on the boundary value instead of rolling over
        if (boundary && (WRAP_MODE == 0)) begin
            next_addr = addr;
        end
    end

endmodule

// File: rtl/mem_address_sequencer.sv
// Memory address register with bus load, single inc/dec and a self-timed burst walker.
// All outputs registered, 1 clk latency from command to AddressOut.
// Burst AddrValid holds AddressOut stable until AddrReady; commands outside IDLE are dropped.
module mem_address_sequencer
    import mem_address_sequencer_pkg::*;
#(
    parameter int BUS_W     = 16,
    parameter int ADDR_W    = 8,
    parameter int LEN_W     = 4,
    parameter int WRAP_MODE = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    inout  wire  [BUS_W-1:0]  Bus,
    input  logic              RegIn,
    input  logic              LenIn,
    input  logic              Inc,
    input  logic              Dec,
    input  logic              Start,
    input  logic              Dir,
    input  logic              AddrReady,
    input  logic              ClrFlags,
    output logic [ADDR_W-1:0] AddressOut,
    output logic              AddrValid,
    output logic              Busy,
    output logic              Done,
    output logic              Wrapped
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    seq_state_t        state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic [LEN_W-1:0]  rem_q, rem_n;
    logic              dir_q, dir_n;
    logic              wrapped_q, wrapped_n;

    logic              step_dir;
    logic              do_step;
    logic [ADDR_W-1:0] step_addr;
    logic              step_bnd;
    logic              unused_bus;

    assign unused_bus = ^Bus;

    mem_address_sequencer_address_stepper #(
        .ADDR_W    (ADDR_W),
        .WRAP_MODE (WRAP_MODE)
    ) u_stepper (
        .addr      (addr_q),
        .dir       (step_dir),
        .next_addr (step_addr),
        .boundary  (step_bnd)
    );

    always_comb begin
        state_n   = state_q;
        addr_n    = addr_q;
        len_n     = len_q;
        rem_n     = rem_q;
        dir_n     = dir_q;
        wrapped_n = wrapped_q & ~ClrFlags;
        step_dir  = dir_q;
        do_step   = 1'b0;

        case (state_q)
            IDLE: begin
                if (RegIn) addr_n = Bus[ADDR_W-1:0];
                if (LenIn) len_n  = Bus[LEN_W-1:0];
                if (Start) begin
                    state_n = RUN;
                    rem_n   = LenIn ? Bus[LEN_W-1:0] : len_q;
                    dir_n   = Dir;
                end else if (!RegIn && (Inc || Dec)) begin
                    step_dir = Inc ? DIR_UP : DIR_DN;
                    do_step  = 1'b1;
                end
            end
            RUN: begin
                // Last beat leaves the final issued address on the port
                if (AddrReady) begin
                    if (rem_q == '0) begin
                        state_n = DONE;
                    end else begin
                        rem_n   = rem_q - LEN_ONE;
                        do_step = 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (do_step) begin
            addr_n = step_addr;
            if (step_bnd) wrapped_n = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            dir_q     <= DIR_UP;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            rem_q     <= rem_n;
            dir_q     <= dir_n;
            wrapped_q <= wrapped_n;
        end
    end

    assign AddressOut = addr_q;
    assign AddrValid  = (state_q == RUN);
    assign Busy       = (state_q != IDLE);
    assign Done       = (state_q == DONE);
    assign Wrapped    = wrapped_q;

endmodule
